// File: rtl/multi_debouncer.sv
// N-channel push-button/switch debouncer: 2-FF synchronizer, stable-time filter,
// registered edge pulses and a long-hold flag per channel.
module multi_debouncer #(
  parameter int   N_CH          = 4,
  parameter int   STABLE_CYCLES = 50_000,
  parameter int   HOLD_CYCLES   = 50_000_000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic            CLK50M,
  input  logic            RESET_N,
  input  logic [N_CH-1:0] NOISY,
  output logic [N_CH-1:0] CLEAN,
  output logic [N_CH-1:0] RISE,
  output logic [N_CH-1:0] FALL,
  output logic [N_CH-1:0] LONG,
  output logic [N_CH-1:0] LONG_PULSE
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_PRE = HCNT_W'(HOLD_CYCLES - 1);

  logic [N_CH-1:0]   sync_p0;
  logic [N_CH-1:0]   sync_p1;
  logic [CNT_W-1:0]  cnt_p2  [N_CH];
  logic [HCNT_W-1:0] hcnt_p3 [N_CH];

  logic [CNT_W-1:0]  cnt_nxt  [N_CH];
  logic [HCNT_W-1:0] hcnt_nxt [N_CH];
  logic [N_CH-1:0]   clean_nxt;
  logic [N_CH-1:0]   rise_nxt;
  logic [N_CH-1:0]   fall_nxt;
  logic [N_CH-1:0]   long_nxt;
  logic [N_CH-1:0]   lpulse_nxt;

  function automatic logic [HCNT_W-1:0] hold_sat_inc(input logic [HCNT_W-1:0] v);
    return (v >= HCNT_MAX) ? HCNT_MAX : v + 1'b1;
  endfunction

  always_comb begin
    clean_nxt  = CLEAN;
    rise_nxt   = '0;
    fall_nxt   = '0;
    long_nxt   = '0;
    lpulse_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i]  = '0;
      hcnt_nxt[i] = '0;

      // stage p2: stable-time filter
      if (sync_p1[i] != CLEAN[i]) begin
        if (cnt_p2[i] == CNT_LAST) begin
          clean_nxt[i] = sync_p1[i];
          rise_nxt[i]  = sync_p1[i];
          fall_nxt[i]  = ~sync_p1[i];
        end else begin
          cnt_nxt[i] = cnt_p2[i] + 1'b1;
        end
      end

      // stage p3: hold timer, cleared on the same edge that drops CLEAN
      if (CLEAN[i] && !fall_nxt[i]) begin
        hcnt_nxt[i]   = hold_sat_inc(hcnt_p3[i]);
        long_nxt[i]   = (hcnt_p3[i] >= HCNT_PRE);
        lpulse_nxt[i] = (hcnt_p3[i] == HCNT_PRE);
      end
    end
  end

  always_ff @(posedge CLK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_p0    <= {N_CH{RESET_LEVEL}};
      sync_p1    <= {N_CH{RESET_LEVEL}};
      CLEAN      <= {N_CH{RESET_LEVEL}};
      RISE       <= '0;
      FALL       <= '0;
      LONG       <= '0;
      LONG_PULSE <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_p2[i]  <= '0;
        hcnt_p3[i] <= '0;
      end
    end else begin
      // stage p0/p1: two-flop synchronizer
      sync_p0    <= NOISY;
      sync_p1    <= sync_p0;
      CLEAN      <= clean_nxt;
      RISE       <= rise_nxt;
      FALL       <= fall_nxt;
      LONG       <= long_nxt;
      LONG_PULSE <= lpulse_nxt;
      for (int i = 0; i < N_CH; i++) begin
        cnt_p2[i]  <= cnt_nxt[i];
        hcnt_p3[i] <= hcnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a behavioural model.
module tb_multi_debouncer;

  localparam int N_CH   = 4;
  localparam int STABLE = 4;
  localparam int HOLD   = 10;

  logic            CLK50M;
  logic            RESET_N;
  logic [N_CH-1:0] noisy;
  logic [N_CH-1:0] clean, rise, fall, long_o, long_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  multi_debouncer #(
    .N_CH(N_CH), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .RESET_LEVEL(1'b0)
  ) dut (
    .CLK50M(CLK50M), .RESET_N(RESET_N), .NOISY(noisy), .CLEAN(clean), .RISE(rise),
    .FALL(fall), .LONG(long_o), .LONG_PULSE(long_pulse)
  );

  initial CLK50M = 1'b0;
  always #5 CLK50M = ~CLK50M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: pin history, disagreement run length, time since CLEAN rose.
  logic [N_CH-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0;
  logic [N_CH-1:0] e_rise = '0, e_fall = '0, e_long = '0, e_lp = '0;
  int m_run   [N_CH];
  int m_since [N_CH];
  int cyc = 0;

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      m_run[i]   = 0;
      m_since[i] = 0;
    end
    forever begin
      @(posedge CLK50M);
      if (!RESET_N) begin
        m_s1 = '0; m_s2 = '0; m_clean = '0;
        e_rise = '0; e_fall = '0; e_long = '0; e_lp = '0;
        for (int i = 0; i < N_CH; i++) m_run[i] = 0;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          logic nc;
          nc = m_clean[i];
          if (m_s2[i] != m_clean[i]) begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin
              nc = m_s2[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
          e_rise[i] = nc & ~m_clean[i];
          e_fall[i] = ~nc & m_clean[i];
          if (e_rise[i]) m_since[i] = cyc;
          m_clean[i] = nc;
          e_long[i]  = nc && (cyc - m_since[i] >= HOLD);
          e_lp[i]    = nc && (cyc - m_since[i] == HOLD);
          m_s2[i] = m_s1[i];
          m_s1[i] = noisy[i];
        end
      end
      cyc++;
      #1;
      check("model_clean", 32'(clean), 32'(m_clean));
      check("model_rise", 32'(rise), 32'(e_rise));
      check("model_fall", 32'(fall), 32'(e_fall));
      check("model_long", 32'(long_o), 32'(e_long));
      check("model_long_pulse", 32'(long_pulse), 32'(e_lp));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK50M);
  endtask

  initial begin
    RESET_N = 1'b0;
    noisy   = '0;
    tick(3);
    check("reset_clean", 32'(clean), 32'd0);
    check("reset_pulses", 32'({rise, fall, long_o, long_pulse}), 32'd0);
    RESET_N = 1'b1;
    tick(2);

    // Clean press and release on channel 0
    noisy[0] = 1'b1;
    tick(5);
    check("press_clean_early", 32'(clean[0]), 32'd0);
    tick(1);
    check("press_clean", 32'(clean[0]), 32'd1);
    check("press_rise", 32'(rise[0]), 32'd1);
    tick(1);
    check("press_rise_gone", 32'(rise[0]), 32'd0);
    noisy[0] = 1'b0;
    tick(5);
    check("release_fall_early", 32'(fall[0]), 32'd0);
    tick(1);
    check("release_fall", 32'(fall[0]), 32'd1);
    check("release_clean", 32'(clean[0]), 32'd0);

    // Bounce on channel 1: 3 high / 1 low never accepted
    for (int k = 0; k < 5; k++) begin
      noisy[1] = 1'b1;
      tick(3);
      noisy[1] = 1'b0;
      tick(1);
    end
    tick(2);
    check("bounce_clean", 32'(clean[1]), 32'd0);
    noisy[1] = 1'b1;
    tick(5);
    check("bounce_steady_early", 32'(clean[1]), 32'd0);
    tick(1);
    check("bounce_steady_rise", 32'(rise[1]), 32'd1);

    // Glitch on channel 2 while high
    noisy[2] = 1'b1;
    tick(8);
    check("glitch_pre", 32'(clean[2]), 32'd1);
    noisy[2] = 1'b0;
    tick(3);
    noisy[2] = 1'b1;
    tick(8);
    check("glitch_clean", 32'(clean[2]), 32'd1);

    // Long hold on channel 3
    noisy[3] = 1'b1;
    tick(6);
    check("hold_rise", 32'(rise[3]), 32'd1);
    tick(9);
    check("hold_pulse_early", 32'({long_o[3], long_pulse[3]}), 32'd0);
    tick(1);
    check("hold_pulse", 32'({long_o[3], long_pulse[3]}), 32'd3);
    tick(1);
    check("hold_pulse_once", 32'({long_o[3], long_pulse[3]}), 32'd2);
    tick(10);
    check("hold_steady", 32'({long_o[3], long_pulse[3]}), 32'd2);
    noisy[3] = 1'b0;
    tick(5);
    check("hold_release_early", 32'({long_o[3], fall[3]}), 32'd2);
    tick(1);
    check("hold_release", 32'({long_o[3], fall[3]}), 32'd1);

    // Async reset with all channels high, then simultaneous rise
    noisy = '0;
    tick(8);
    noisy = 4'hF;
    tick(8);
    check("all_high", 32'(clean), 32'hF);
    #2 RESET_N = 1'b0;
    #1;
    check("async_reset_clean", 32'(clean), 32'd0);
    check("async_reset_rest", 32'({rise, fall, long_o, long_pulse}), 32'd0);
    tick(2);
    RESET_N = 1'b1;
    tick(5);
    check("post_reset_early", 32'(clean), 32'd0);
    tick(1);
    check("simul_rise", 32'(rise), 32'hF);
    check("simul_clean", 32'(clean), 32'hF);
    tick(1);
    check("simul_rise_gone", 32'(rise), 32'd0);

    // Reset mid-window discards the partial count
    noisy = '0;
    tick(8);
    noisy = 4'hF;
    tick(4);
    #2 RESET_N = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(5);
    check("midwin_early", 32'(clean), 32'd0);
    check("midwin_no_pulse", 32'(rise), 32'd0);
    tick(1);
    check("midwin_rise", 32'(rise), 32'hF);

    // Randomized run
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK50M);
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 2 + 2 * i) == 0) noisy[i] = ~noisy[i];
      if ($urandom_range(0, 399) == 0) begin
        #2 RESET_N = 1'b0;
        @(negedge CLK50M);
        RESET_N = 1'b1;
      end
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
